// File: rtl/mm_pkg.sv
// Shared types and default sizing for the matrix-multiply stream controller.
package mm_pkg;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_A_DEPTH_BITS   = 3;
  localparam int DEF_B_DEPTH_BITS   = 2;
  localparam int DEF_AXIS_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_A,
    ST_READ_B,
    ST_COMPUTE,
    ST_OUT_FETCH,
    ST_OUT_LATCH,
    ST_OUT_SEND
  } state_e;

endpackage

// File: rtl/mm_stream_ctrl.sv
// Sequences slave-stream words into A/B RAMs, runs the multiplier, then
// streams RES_RAM out on the master stream with TLAST on the final word.
//
// state      | meaning
// IDLE       | waiting for first input word, nothing consumed
// READ_A     | accepting A words into A_RAM
// READ_B     | accepting B words into B_RAM
// COMPUTE    | Start held high until Done
// OUT_FETCH  | RES_RAM read issued for current index
// OUT_LATCH  | read data captured into output register
// OUT_SEND   | output word valid, waiting for TREADY
module mm_stream_ctrl
  import mm_pkg::*;
#(
  parameter int width              = DEF_WIDTH,
  parameter int A_depth_bits       = DEF_A_DEPTH_BITS,
  parameter int B_depth_bits       = DEF_B_DEPTH_BITS,
  parameter int RES_depth_bits     = A_depth_bits - B_depth_bits,
  parameter int C_AXIS_TDATA_WIDTH = DEF_AXIS_WIDTH
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  output logic                          A_write_en,
  output logic [A_depth_bits-1:0]       A_write_address,
  output logic [width-1:0]              A_write_data_in,
  output logic                          B_write_en,
  output logic [B_depth_bits-1:0]       B_write_address,
  output logic [width-1:0]              B_write_data_in,
  output logic                          Start,
  input  logic                          Done,
  output logic                          RES_read_en,
  output logic [RES_depth_bits-1:0]     RES_read_address,
  input  logic [width-1:0]              RES_read_data_in
);

  state_e                          state_q;
  logic [A_depth_bits-1:0]         cnt_q;
  logic [RES_depth_bits-1:0]       res_idx_q;
  logic                            start_q;
  logic                            m_tvalid_q;
  logic                            m_tlast_q;
  logic [C_AXIS_TDATA_WIDTH-1:0]   m_tdata_q;

  // Frame boundaries come from word counts only; input TLAST and the upper
  // data bits beyond the RAM width carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXIS_TDATA[C_AXIS_TDATA_WIDTH-1:width], S_AXIS_TLAST};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      res_idx_q  <= '0;
      start_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (S_AXIS_TVALID) state_q <= ST_READ_A;
        end
        ST_READ_A: begin
          if (S_AXIS_TVALID) begin
            if (cnt_q == '1) begin
              cnt_q   <= '0;
              state_q <= ST_READ_B;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_READ_B: begin
          if (S_AXIS_TVALID) begin
            if (cnt_q[B_depth_bits-1:0] == '1) begin
              cnt_q   <= '0;
              start_q <= 1'b1;
              state_q <= ST_COMPUTE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (Done) begin
            start_q   <= 1'b0;
            res_idx_q <= '0;
            state_q   <= ST_OUT_FETCH;
          end
        end
        ST_OUT_FETCH: state_q <= ST_OUT_LATCH;
        ST_OUT_LATCH: begin
          m_tdata_q  <= C_AXIS_TDATA_WIDTH'(RES_read_data_in);
          m_tvalid_q <= 1'b1;
          m_tlast_q  <= (res_idx_q == '1);
          state_q    <= ST_OUT_SEND;
        end
        ST_OUT_SEND: begin
          if (M_AXIS_TREADY) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            if (m_tlast_q) begin
              state_q <= ST_IDLE;
            end else begin
              res_idx_q <= res_idx_q + 1'b1;
              state_q   <= ST_OUT_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S_AXIS_TREADY    = (state_q == ST_READ_A) || (state_q == ST_READ_B);
  assign A_write_en       = (state_q == ST_READ_A) && S_AXIS_TVALID;
  assign A_write_address  = cnt_q;
  assign A_write_data_in  = S_AXIS_TDATA[width-1:0];
  assign B_write_en       = (state_q == ST_READ_B) && S_AXIS_TVALID;
  assign B_write_address  = cnt_q[B_depth_bits-1:0];
  assign B_write_data_in  = S_AXIS_TDATA[width-1:0];
  assign Start            = start_q;
  assign RES_read_en      = (state_q == ST_OUT_FETCH);
  assign RES_read_address = res_idx_q;
  assign M_AXIS_TVALID    = m_tvalid_q;
  assign M_AXIS_TLAST     = m_tlast_q;
  assign M_AXIS_TDATA     = m_tdata_q;

endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Self-checking bench for mm_stream_ctrl with behavioural RAMs and multiplier.
module tb_mm_stream_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [31:0] S_AXIS_TDATA;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [31:0] M_AXIS_TDATA;
  logic        A_write_en, B_write_en, Start, Done, RES_read_en;
  logic [2:0]  A_write_address;
  logic [1:0]  B_write_address;
  logic [7:0]  A_write_data_in, B_write_data_in, RES_read_data_in;
  logic [0:0]  RES_read_address;

  always #5 ACLK = ~ACLK;

  mm_stream_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .A_write_en(A_write_en), .A_write_address(A_write_address), .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .Start(Start), .Done(Done),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
    .RES_read_data_in(RES_read_data_in)
  );

  int n_pass = 0;
  int n_total = 0;

  // ---------------- external RAMs and multiplier ----------------
  logic [7:0]  a_ram [8];
  logic [7:0]  b_ram [4];
  logic [7:0]  res_ram [2];
  logic [15:0] a_log [$];
  logic [15:0] b_log [$];

  always @(posedge ACLK) begin
    if (A_write_en) begin
      a_ram[A_write_address] <= A_write_data_in;
      a_log.push_back({5'd0, A_write_address, A_write_data_in});
    end
    if (B_write_en) begin
      b_ram[B_write_address] <= B_write_data_in;
      b_log.push_back({6'd0, B_write_address, B_write_data_in});
    end
    if (RES_read_en) RES_read_data_in <= res_ram[RES_read_address];
  end

  int   mm_lat = 4;
  int   mm_cnt = 0;
  bit   mm_fired = 0;
  logic mm_done = 1'b0;
  logic extra_done = 1'b0;
  assign Done = mm_done | extra_done;

  always @(posedge ACLK) begin
    #1;
    if (!Start) begin
      mm_cnt = 0; mm_fired = 0; mm_done = 1'b0;
    end else if (mm_done) begin
      mm_done = 1'b0;
    end else if (!mm_fired) begin
      if (mm_cnt >= mm_lat) begin
        for (int r = 0; r < 2; r++) begin
          logic [7:0] acc;
          acc = 8'd0;
          for (int c = 0; c < 4; c++) acc = acc + 8'(a_ram[r*4+c] * b_ram[c]);
          res_ram[r] = acc;
        end
        mm_done = 1'b1; mm_fired = 1;
      end else begin
        mm_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] frm [12];

  function automatic logic [31:0] exp_word(input int row);
    int sum = 0;
    for (int c = 0; c < 4; c++) sum += int'(frm[row*4+c] % 256) * int'(frm[8+c] % 256);
    return 32'(sum % 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_tready"}, S_AXIS_TREADY, 0);
    check({tag, "_m_tvalid"}, M_AXIS_TVALID, 0);
    check({tag, "_m_tdata"}, M_AXIS_TDATA, 0);
    check({tag, "_m_tlast"}, M_AXIS_TLAST, 0);
    check({tag, "_start"}, Start, 0);
    check({tag, "_res_en"}, RES_read_en, 0);
    check({tag, "_res_addr"}, RES_read_address, 0);
    check({tag, "_a_we"}, A_write_en, 0);
    check({tag, "_b_we"}, B_write_en, 0);
  endtask

  task automatic load_nominal();
    for (int i = 0; i < 8; i++) frm[i] = 32'(i + 1);
    for (int j = 0; j < 4; j++) frm[8+j] = 32'(j + 1);
  endtask

  task automatic load_random(input bit all_ff);
    for (int i = 0; i < 12; i++) begin
      frm[i] = $urandom;
      if (all_ff) frm[i][7:0] = 8'hFF;
    end
  endtask

  task automatic send_words(input int first, input int count, input int gap);
    int k = first;
    int guard = 0;
    bit hs;
    while (k < first + count && guard < 500) begin
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = frm[k];
      S_AXIS_TLAST  = (k == 11);
      @(negedge ACLK);
      hs = S_AXIS_TREADY;
      if (k == 0 && guard == 0) check("start_low_before_frame", Start, 0);
      if (hs && k == 11) check("start_before_final_edge", Start, 0);
      @(posedge ACLK); #1;
      guard++;
      if (hs) begin
        k++;
        if (k == 12) begin
          S_AXIS_TVALID = 1'b0;
          @(negedge ACLK);
          check("start_after_final_b", Start, 1);
        end
        if (gap > 0) begin
          S_AXIS_TVALID = 1'b0;
          repeat (gap) begin @(posedge ACLK); #1; end
        end
      end
    end
    S_AXIS_TVALID = 1'b0;
    if (guard >= 500) check("send_timeout", 0, 1);
  endtask

  task automatic recv_frame(input int bp_word, input int bp_cycles);
    for (int w = 0; w < 2; w++) begin
      int guard = 0;
      bit fetched = 0;
      M_AXIS_TREADY = 1'b1;
      while (!M_AXIS_TVALID && guard < 300) begin
        if (RES_read_en) begin
          fetched = 1;
          check("res_addr", 32'(RES_read_address), 32'(w));
        end
        @(negedge ACLK);
        guard++;
      end
      if (guard >= 300) begin
        check("out_timeout", 0, 1);
        return;
      end
      check("fetch_seen", fetched, 1);
      if (w > 0) check("word_gap", 32'(guard), 2);
      check("tdata", M_AXIS_TDATA, exp_word(w));
      check("tlast", M_AXIS_TLAST, (w == 1));
      if (w == bp_word) begin
        M_AXIS_TREADY = 1'b0;
        for (int c = 0; c < bp_cycles; c++) begin
          @(negedge ACLK);
          check("bp_tvalid", M_AXIS_TVALID, 1);
          check("bp_tdata", M_AXIS_TDATA, exp_word(w));
          check("bp_tlast", M_AXIS_TLAST, (w == 1));
        end
        M_AXIS_TREADY = 1'b1;
      end
      @(negedge ACLK);
      check("tvalid_drop", M_AXIS_TVALID, 0);
      check("tlast_drop", M_AXIS_TLAST, 0);
    end
    check("idle_tready", S_AXIS_TREADY, 0);
  endtask

  task automatic check_logs();
    check("a_log_size", 32'(a_log.size()), 8);
    check("b_log_size", 32'(b_log.size()), 4);
    for (int i = 0; i < 8 && i < a_log.size(); i++)
      check("a_write", 32'(a_log[i]), {21'd0, 3'(i), frm[i][7:0]});
    for (int j = 0; j < 4 && j < b_log.size(); j++)
      check("b_write", 32'(b_log[j]), {22'd0, 2'(j), frm[8+j][7:0]});
  endtask

  task automatic run_frame(input int gap, input int bp_word, input int bp_cycles);
    a_log.delete();
    b_log.delete();
    send_words(0, 12, gap);
    recv_frame(bp_word, bp_cycles);
    check_logs();
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_after_reset", S_AXIS_TREADY, 0);

    load_nominal();
    run_frame(0, -1, 0);
    run_frame(2, -1, 0);
    run_frame(0, 0, 5);

    // reset in the middle of the A frame, with input still valid
    send_words(0, 3, 0);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = frm[3];
    #2 ARESETN = 1'b0;
    #1 check_all_zero("rst_midstream");
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b0;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_after_mid_reset", S_AXIS_TREADY, 0);

    // reset while Start is held
    mm_lat = 40;
    send_words(0, 12, 0);
    repeat (3) @(negedge ACLK);
    check("start_in_compute", Start, 1);
    #2 ARESETN = 1'b0;
    #1 check_all_zero("rst_compute");
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    mm_lat = 4;
    run_frame(0, -1, 0);

    // truncating accumulate, two frames back to back
    load_random(1);
    check("ff_model", exp_word(0), 32'h4);
    mm_lat = $urandom_range(3, 8);
    run_frame(0, -1, 0);
    load_random(1);
    run_frame(0, -1, 0);

    // Done outside COMPUTE must do nothing
    @(negedge ACLK);
    extra_done = 1'b1;
    @(negedge ACLK);
    extra_done = 1'b0;
    check("spurious_done_start", Start, 0);
    check("spurious_done_tvalid", M_AXIS_TVALID, 0);
    @(negedge ACLK);
    check("spurious_done_fetch", RES_read_en, 0);
    check("spurious_done_tvalid2", M_AXIS_TVALID, 0);

    for (int f = 0; f < 4; f++) begin
      load_random(0);
      mm_lat = $urandom_range(3, 8);
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
